// File: rtl/odd_permute_pipe.sv
// odd_permute_pipe: pipelined quadword shift/rotate/gather unit for the odd pipe.
// Define PERMUTE_GATHER_EN to build GBB/GBH/GB; otherwise op_sel 10-12 flag out_err.
module odd_permute_pipe #(
  parameter int DATA_W = 128,
  parameter int STAGES = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] rb,
  input  logic [6:0]        i7,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [ADDR_W-1:0] out_rt,
  output logic              out_err
);

  localparam int NB = DATA_W / 8;
  localparam int CB = $clog2(NB);

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] res;
  } stage_t;

  stage_t pipe_q [STAGES];
  stage_t d;

  logic stall;
  logic fire;

  logic [2:0]  bit_rb;
  logic [2:0]  bit_i7;
  logic [CB:0] byte_rb;
  logic [CB:0] byte_i7;
  logic [CB:0] byte_bi;
  logic        unused_ok;

  assign bit_rb    = rb[2:0];
  assign bit_i7    = i7[2:0];
  assign byte_rb   = rb[CB:0];
  assign byte_i7   = i7[CB:0];
  assign byte_bi   = rb[CB+3:3];
  assign unused_ok = ^{rb, i7};

  // Shift amount of DATA_W on the right half yields 0, so n=0 is a plain copy.
  function automatic logic [DATA_W-1:0] rotl(
    input logic [DATA_W-1:0] x,
    input logic [9:0]        n
  );
    return (x << n) | (x >> (10'(DATA_W) - n));
  endfunction

  function automatic logic [DATA_W-1:0] shl_by(
    input logic [DATA_W-1:0] x,
    input logic [CB:0]       c
  );
    return c[CB] ? '0 : x << {c, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] rot_by(
    input logic [DATA_W-1:0] x,
    input logic [CB:0]       c
  );
    return rotl(x, 10'({c[CB-1:0], 3'b000}));
  endfunction

`ifdef PERMUTE_GATHER_EN
  localparam int GBB_N = (NB > 32) ? 32 : NB;

  logic [31:0] gbb;
  logic [31:0] gbh;
  logic [31:0] gb;

  always_comb begin
    gbb = '0;
    gbh = '0;
    gb  = '0;
    for (int j = 0; j < GBB_N; j++) gbb[j] = ra[8*j];
    for (int j = 0; j < DATA_W/16; j++) gbh[j] = ra[16*j];
    for (int j = 0; j < DATA_W/32; j++) gb[j] = ra[32*j];
  end
`endif

  assign stall    = pipe_q[STAGES-1].vld && !out_ready;
  assign in_ready = !flush && !stall;
  assign fire     = in_valid && in_ready;

  always_comb begin
    d     = '0;
    d.vld = fire;
    d.rt  = rt_addr;
    unique case (op_sel)
      4'd0:  d.res = ra << bit_rb;
      4'd1:  d.res = ra << bit_i7;
      4'd2:  d.res = shl_by(ra, byte_rb);
      4'd3:  d.res = shl_by(ra, byte_i7);
      4'd4:  d.res = shl_by(ra, byte_bi);
      4'd5:  d.res = rot_by(ra, byte_rb);
      4'd6:  d.res = rot_by(ra, byte_i7);
      4'd7:  d.res = rot_by(ra, byte_bi);
      4'd8:  d.res = rotl(ra, 10'(bit_rb));
      4'd9:  d.res = rotl(ra, 10'(bit_i7));
`ifdef PERMUTE_GATHER_EN
      4'd10: d.res[DATA_W-1 -: 32] = gbb;
      4'd11: d.res[DATA_W-1 -: 32] = gbh;
      4'd12: d.res[DATA_W-1 -: 32] = gb;
`endif
      default: d.err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i].vld <= 1'b0;
    end else if (!stall) begin
      pipe_q[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_valid  = pipe_q[STAGES-1].vld;
  assign out_result = pipe_q[STAGES-1].res;
  assign out_rt     = pipe_q[STAGES-1].rt;
  assign out_err    = pipe_q[STAGES-1].err;

endmodule

// File: tb/tb_odd_permute_pipe.sv
// tb_odd_permute_pipe: directed table, corner sequences and random ops
// against a big-endian bit-array reference model.
module tb_odd_permute_pipe;

  localparam int W  = 128;
  localparam int ST = 4;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op_sel = '0;
  logic [W-1:0]  ra = '0;
  logic [W-1:0]  rb = '0;
  logic [6:0]    i7 = '0;
  logic [AW-1:0] rt_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [AW-1:0] out_rt;
  logic          out_err;

  always #5 clock = ~clock;

  odd_permute_pipe #(.DATA_W(W), .STAGES(ST), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .ra         (ra),
    .rb         (rb),
    .i7         (i7),
    .rt_addr    (rt_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rt     (out_rt),
    .out_err    (out_err)
  );

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [6:0]    i7;
    logic [AW-1:0] rt;
    logic [W-1:0]  res;
    logic          err;
  } vec_t;

  typedef struct {
    logic [W-1:0]  res;
    logic [AW-1:0] rt;
    logic          err;
    int            t;
  } exp_t;

  vec_t tbl [16];
  vec_t idle;
  exp_t q [$];

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int pops = 0;
  logic acc = 1'b0;
  logic last_ready = 1'b0;
  logic chk_lat = 1'b0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_res = '0;

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int imm,
                              input int rt, input logic [W-1:0] res,
                              input logic err);
    vec_t v;
    v.op = 4'(op);
    v.ra = a;
    v.rb = b;
    v.i7 = 7'(imm);
    v.rt = AW'(rt);
    v.res = res;
    v.err = err;
    return v;
  endfunction

  // Bits indexed big-endian: be[k] is a[W-1-k].
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [6:0] imm,
                                output logic [W-1:0] res, output logic err);
    int bc_b, by_b, bi_b, bc_i, by_i, n, esz, s;
    bit rot;
    logic [W-1:0] f;
    bc_b = int'(b % 8);
    by_b = int'(b % 32);
    bi_b = int'((b / 8) % 32);
    bc_i = int'(imm % 8);
    by_i = int'(imm % 32);
    res = '0; err = 1'b0; n = 0; esz = 0; rot = 1'b0; f = '0;
    case (op)
      4'd0: n = bc_b;
      4'd1: n = bc_i;
      4'd2: n = 8 * by_b;
      4'd3: n = 8 * by_i;
      4'd4: n = 8 * bi_b;
      4'd5: begin rot = 1'b1; n = 8 * (by_b % 16); end
      4'd6: begin rot = 1'b1; n = 8 * (by_i % 16); end
      4'd7: begin rot = 1'b1; n = 8 * (bi_b % 16); end
      4'd8: begin rot = 1'b1; n = bc_b; end
      4'd9: begin rot = 1'b1; n = bc_i; end
`ifdef PERMUTE_GATHER_EN
      4'd10: esz = 8;
      4'd11: esz = 16;
      4'd12: esz = 32;
`endif
      default: err = 1'b1;
    endcase
    if (esz != 0) begin
      for (int e = 0; e < W / esz; e++)
        f = (f << 1) | W'(a[W - (e + 1) * esz]);
      res = (f & W'(32'hFFFF_FFFF)) << (W - 32);
    end else if (!err) begin
      for (int k = 0; k < W; k++) begin
        s = rot ? (k + n) % W : k + n;
        if (s < W) res[W-1-k] = a[W-1-s];
      end
    end
  endfunction

  task automatic cyc(input logic v, input vec_t x, input logic ordy,
                     input logic fl);
    exp_t e;
    in_valid = v; op_sel = x.op; ra = x.ra; rb = x.rb; i7 = x.i7;
    rt_addr = x.rt; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", W'(in_ready), W'(!fl && (!out_valid || ordy)));
    if (prev_stall) begin
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_result", out_result, prev_res);
    end
    last_ready = in_ready;
    acc = v && in_ready;
    if (out_valid && ordy && !fl) begin
      if (q.size() == 0) begin
        chk("unexpected_out", W'(out_valid), W'(0));
      end else begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("rt", W'(out_rt), W'(e.rt));
        chk("err", W'(out_err), W'(e.err));
        if (chk_lat) chk("latency", W'(tick - e.t), W'(ST));
        pops++;
      end
    end
    prev_stall = out_valid && !ordy && !fl;
    prev_res = out_result;
    if (acc) q.push_back('{res: x.res, rt: x.rt, err: x.err, t: tick});
    tick++;
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      cyc(1'b0, idle, 1'b1, 1'b0);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", W'(q.size()), W'(0));
      q.delete();
    end
  endtask

  task automatic quiet(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      cyc(1'b0, idle, 1'b1, 1'b0);
      chk(name, W'(out_valid), W'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int idx, p0;
    logic ordy;
    vec_t x;
    logic [W-1:0] one;
    logic [W-1:0] ones;
    logic gerr;
    logic [W-1:0] g1, g255;
    one  = W'(1);
    ones = '1;
    idle = mk(0, '0, '0, 0, 0, '0, 1'b0);
`ifdef PERMUTE_GATHER_EN
    gerr = 1'b0; g1 = one << 96; g255 = W'(255) << 96;
`else
    gerr = 1'b1; g1 = '0; g255 = '0;
`endif
    tbl[0]  = mk(0,  W'(20), W'(10), 0, 5, W'(80), 1'b0);
    tbl[1]  = mk(2,  W'(25), W'(110), 0, 6, W'(25) << 112, 1'b0);
    tbl[2]  = mk(3,  W'(33), '0, 15, 7, W'(33) << 120, 1'b0);
    tbl[3]  = mk(2,  W'(25), W'(16), 0, 8, '0, 1'b0);
    tbl[4]  = mk(5,  W'(77), W'(34), 0, 9, W'(77) << 16, 1'b0);
    tbl[5]  = mk(9,  one << 127, '0, 5, 10, W'(16), 1'b0);
    tbl[6]  = mk(12, W'(45), '0, 0, 11, g1, gerr);
    tbl[7]  = mk(10, W'(15), '0, 0, 12, g1, gerr);
    tbl[8]  = mk(11, ones, '0, 0, 13, g255, gerr);
    tbl[9]  = mk(14, ones, W'(3), 3, 14, '0, 1'b1);
    tbl[10] = mk(8,  (one << 127) | one, W'(1), 0, 15, W'(3), 1'b0);
    tbl[11] = mk(4,  one, W'(24), 0, 16, one << 24, 1'b0);
    tbl[12] = mk(7,  W'(8'hAB) << 120, W'(8), 0, 17, W'(8'hAB), 1'b0);
    tbl[13] = mk(1,  W'(3), '0, 127, 18, W'(384), 1'b0);
    tbl[14] = mk(6,  one << 127, '0, 17, 19, W'(128), 1'b0);
    tbl[15] = mk(3,  W'(5), '0, 16, 20, '0, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_out_result", out_result, '0);
    chk("reset_out_rt", W'(out_rt), W'(0));
    chk("reset_out_err", W'(out_err), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, tbl[i], 1'b1, 1'b0);
      drain(20);
    end
    chk_lat = 1'b0;

    idx = 0;
    p0 = pops;
    for (int t = 0; t < 60 && (idx < 6 || q.size() > 0); t++) begin
      ordy = !(t >= 5 && t <= 7);
      cyc(idx < 6, tbl[idx < 6 ? idx : 0], ordy, 1'b0);
      if (t >= 5 && t <= 7) chk("stall_in_ready", W'(last_ready), W'(0));
      if (acc) idx++;
    end
    chk("b2b_count", W'(pops - p0), W'(6));
    drain(20);

    for (int i = 0; i < 3; i++) cyc(1'b1, tbl[i], 1'b1, 1'b0);
    cyc(1'b1, tbl[3], 1'b0, 1'b1);
    q.delete();
    prev_stall = 1'b0;
    quiet("no_out_after_flush", 4);
    cyc(1'b1, tbl[4], 1'b1, 1'b0);
    drain(20);

    for (int i = 0; i < 6; i++) cyc(1'b1, tbl[i + 4], 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_valid", W'(out_valid), W'(0));
    q.delete();
    prev_stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    quiet("no_out_after_reset", 4);
    cyc(1'b1, tbl[5], 1'b1, 1'b0);
    drain(20);

    for (int t = 0; t < 400; t++) begin
      x.op = 4'($urandom % 16);
      x.ra = {$urandom, $urandom, $urandom, $urandom};
      x.rb = {$urandom, $urandom, $urandom, $urandom};
      x.i7 = 7'($urandom % 128);
      x.rt = AW'($urandom % 128);
      model(x.op, x.ra, x.rb, x.i7, x.res, x.err);
      cyc(($urandom % 4) != 0, x, ($urandom % 3) != 0, 1'b0);
    end
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
